// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// Detects a committing ecall, mret or pending machine timer interrupt,
// writes mepc / mcause / mstatus one per cycle through the clint CSR
// write port, then redirects the fetch PC.
module trap_ctrl #(
  parameter logic [63:0] MCAUSE_ECALL = 64'd11,
  parameter logic [63:0] MCAUSE_MTI   = 64'h8000_0000_0000_0007
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [63:0] pc_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        cpu_csr_wen_i,
  input  logic [63:0] csr_mtvec_i,
  input  logic [63:0] csr_mepc_i,
  input  logic [63:0] csr_mstatus_i,
  input  logic        global_int_en_i,
  input  logic        mtime_int_en_i,
  input  logic        mtime_int_pend_i,
  output logic        csr_wen_o,
  output logic [11:0] csr_waddr_o,
  output logic [63:0] csr_wdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic        busy_o
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SAVE_EPC    = 3'd1;
  localparam logic [2:0] S_SAVE_CAUSE  = 3'd2;
  localparam logic [2:0] S_SET_STATUS  = 3'd3;
  localparam logic [2:0] S_TRAP_JUMP   = 3'd4;
  localparam logic [2:0] S_MRET_STATUS = 3'd5;
  localparam logic [2:0] S_MRET_JUMP   = 3'd6;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  // mstatus on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [63:0] trap_mstatus(input logic [63:0] st);
    logic [63:0] r;
    r         = st;
    r[7]      = st[3];
    r[3]      = 1'b0;
    r[12:11]  = 2'b11;
    return r;
  endfunction

  // mstatus on mret: MIE <= MPIE, MPIE <= 1, MPP stays M (single-mode core).
  function automatic logic [63:0] mret_mstatus(input logic [63:0] st);
    logic [63:0] r;
    r         = st;
    r[3]      = st[7];
    r[7]      = 1'b1;
    r[12:11]  = 2'b11;
    return r;
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [63:0] epc_r;
  logic [63:0] cause_r;
  logic        is_int_r;

  logic        idle_s;
  logic        int_s;
  logic        trap_accept_s;
  logic        mret_accept_s;
  logic        accept_s;
  logic [63:0] tvec_base_s;
  logic [63:0] tvec_off_s;

  assign idle_s        = (state_r == S_IDLE);
  assign int_s         = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
  // Accept is gated by rst_n so nothing is flushed or stalled while in reset.
  assign trap_accept_s = rst_n & idle_s & inst_valid_i & (int_s | ecall_i);
  assign mret_accept_s = rst_n & idle_s & inst_valid_i & ~int_s & ~ecall_i & mret_i;
  assign accept_s      = trap_accept_s | mret_accept_s;
  assign tvec_base_s   = {csr_mtvec_i[63:2], 2'b00};
  assign tvec_off_s    = {56'd0, cause_r[5:0], 2'b00};

  // Next-state logic; write states hold while the pipeline owns the CSR file.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (trap_accept_s) begin
          state_nxt_s = S_SAVE_EPC;
        end else if (mret_accept_s) begin
          state_nxt_s = S_MRET_STATUS;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SAVE_EPC:    state_nxt_s = cpu_csr_wen_i ? S_SAVE_EPC    : S_SAVE_CAUSE;
      S_SAVE_CAUSE:  state_nxt_s = cpu_csr_wen_i ? S_SAVE_CAUSE  : S_SET_STATUS;
      S_SET_STATUS:  state_nxt_s = cpu_csr_wen_i ? S_SET_STATUS  : S_TRAP_JUMP;
      S_TRAP_JUMP:   state_nxt_s = S_IDLE;
      S_MRET_STATUS: state_nxt_s = cpu_csr_wen_i ? S_MRET_STATUS : S_MRET_JUMP;
      S_MRET_JUMP:   state_nxt_s = S_IDLE;
      default:       state_nxt_s = S_IDLE;
    endcase
  end

  // State register plus trap context latched on the accept cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      epc_r    <= 64'd0;
      cause_r  <= 64'd0;
      is_int_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        epc_r    <= pc_i;
        cause_r  <= int_s ? MCAUSE_MTI : MCAUSE_ECALL;
        is_int_r <= int_s;
      end else begin
        epc_r    <= epc_r;
        cause_r  <= cause_r;
        is_int_r <= is_int_r;
      end
    end
  end

  // Output decode from registered state and latched trap context.
  always_comb begin
    csr_wen_o        = 1'b0;
    csr_waddr_o      = 12'h000;
    csr_wdata_o      = 64'd0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 64'd0;
    case (state_r)
      S_SAVE_EPC: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = epc_r;
      end
      S_SAVE_CAUSE: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_r;
      end
      S_SET_STATUS: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = trap_mstatus(csr_mstatus_i);
      end
      S_TRAP_JUMP: begin
        redirect_valid_o = 1'b1;
        if ((csr_mtvec_i[1:0] == 2'b01) && is_int_r) begin
          redirect_pc_o = tvec_base_s + tvec_off_s;
        end else begin
          redirect_pc_o = tvec_base_s;
        end
      end
      S_MRET_STATUS: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mret_mstatus(csr_mstatus_i);
      end
      S_MRET_JUMP: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = csr_mepc_i;
      end
      default: begin
        csr_wen_o        = 1'b0;
        csr_waddr_o      = 12'h000;
        csr_wdata_o      = 64'd0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 64'd0;
      end
    endcase
  end

  assign busy_o  = ~idle_s;
  assign flush_o = accept_s;
  assign stall_o = busy_o | accept_s;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: ecall, timer (vectored), simultaneous
// interrupt+ecall, mret, write-port conflict and mid-sequence reset.
module tb_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_valid_i;
  logic [63:0] pc_i;
  logic        ecall_i;
  logic        mret_i;
  logic        cpu_csr_wen_i;
  logic [63:0] csr_mtvec_i;
  logic [63:0] csr_mepc_i;
  logic [63:0] csr_mstatus_i;
  logic        global_int_en_i;
  logic        mtime_int_en_i;
  logic        mtime_int_pend_i;
  logic        csr_wen_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] csr_wdata_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        busy_o;

  int total;
  int bad;

  trap_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inst_valid_i     (inst_valid_i),
    .pc_i             (pc_i),
    .ecall_i          (ecall_i),
    .mret_i           (mret_i),
    .cpu_csr_wen_i    (cpu_csr_wen_i),
    .csr_mtvec_i      (csr_mtvec_i),
    .csr_mepc_i       (csr_mepc_i),
    .csr_mstatus_i    (csr_mstatus_i),
    .global_int_en_i  (global_int_en_i),
    .mtime_int_en_i   (mtime_int_en_i),
    .mtime_int_pend_i (mtime_int_pend_i),
    .csr_wen_o        (csr_wen_o),
    .csr_waddr_o      (csr_waddr_o),
    .csr_wdata_o      (csr_wdata_o),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs for the new cycle follow.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then check the whole output set.
  task automatic expect_out(input string tag,
                            input logic        wen,
                            input logic [11:0] addr,
                            input logic [63:0] wdata,
                            input logic        rv,
                            input logic [63:0] rpc,
                            input logic        busy,
                            input logic        stall,
                            input logic        flush);
    #1;
    check({tag, ".wen"},   {63'd0, csr_wen_o},        {63'd0, wen});
    check({tag, ".addr"},  {52'd0, csr_waddr_o},      {52'd0, addr});
    check({tag, ".wdata"}, csr_wdata_o,               wdata);
    check({tag, ".rv"},    {63'd0, redirect_valid_o}, {63'd0, rv});
    check({tag, ".rpc"},   redirect_pc_o,             rpc);
    check({tag, ".busy"},  {63'd0, busy_o},           {63'd0, busy});
    check({tag, ".stall"}, {63'd0, stall_o},          {63'd0, stall});
    check({tag, ".flush"}, {63'd0, flush_o},          {63'd0, flush});
  endtask

  task automatic quiet;
    inst_valid_i     = 1'b0;
    ecall_i          = 1'b0;
    mret_i           = 1'b0;
    cpu_csr_wen_i    = 1'b0;
    global_int_en_i  = 1'b0;
    mtime_int_en_i   = 1'b0;
    mtime_int_pend_i = 1'b0;
  endtask

  // Full ecall sequence with no conflicts; mstatus 0x1888 -> 0x1880.
  task automatic ecall_seq(input string tag, input logic [63:0] pc, input logic [63:0] tvec);
    tick;
    quiet;
    csr_mstatus_i = 64'h1888;
    csr_mtvec_i   = tvec;
    pc_i          = pc;
    inst_valid_i  = 1'b1;
    ecall_i       = 1'b1;
    expect_out({tag, ".T0"}, 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    tick; quiet;
    expect_out({tag, ".T1"}, 1'b1, 12'h341, pc, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out({tag, ".T2"}, 1'b1, 12'h342, 64'd11, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out({tag, ".T3"}, 1'b1, 12'h300, 64'h1880, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out({tag, ".T4"}, 1'b0, 12'h000, 64'd0, 1'b1, {tvec[63:2], 2'b00}, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out({tag, ".T5"}, 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    quiet;
    rst_n         = 1'b0;
    pc_i          = 64'd0;
    csr_mtvec_i   = 64'd0;
    csr_mepc_i    = 64'd0;
    csr_mstatus_i = 64'd0;

    // Reset state
    tick;
    tick;
    expect_out("reset", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick;
    expect_out("idle", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Ecall, direct mtvec
    ecall_seq("ecall", 64'h8000_0010, 64'h8000_1000);

    // Timer interrupt with vectored mtvec: base + 4*7
    tick;
    quiet;
    csr_mstatus_i    = 64'h1888;
    csr_mtvec_i      = 64'h8000_1001;
    pc_i             = 64'h8000_0020;
    inst_valid_i     = 1'b1;
    global_int_en_i  = 1'b1;
    mtime_int_en_i   = 1'b1;
    mtime_int_pend_i = 1'b1;
    expect_out("mti.T0", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    tick; quiet;
    expect_out("mti.T1", 1'b1, 12'h341, 64'h8000_0020, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("mti.T2", 1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("mti.T3", 1'b1, 12'h300, 64'h1880, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("mti.T4", 1'b0, 12'h000, 64'd0, 1'b1, 64'h8000_101C, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("mti.T5", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Interrupt and ecall together: interrupt wins, mepc = ecall PC, direct mtvec
    tick;
    quiet;
    csr_mtvec_i      = 64'h8000_1000;
    pc_i             = 64'h8000_0030;
    inst_valid_i     = 1'b1;
    ecall_i          = 1'b1;
    global_int_en_i  = 1'b1;
    mtime_int_en_i   = 1'b1;
    mtime_int_pend_i = 1'b1;
    expect_out("both.T0", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    tick; quiet;
    expect_out("both.T1", 1'b1, 12'h341, 64'h8000_0030, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("both.T2", 1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("both.T3", 1'b1, 12'h300, 64'h1880, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("both.T4", 1'b0, 12'h000, 64'd0, 1'b1, 64'h8000_1000, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("both.T5", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    tick;
    expect_out("both.T6", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Mret: mstatus 0x1880 -> 0x1888, redirect to mepc
    tick;
    quiet;
    csr_mstatus_i = 64'h1880;
    csr_mepc_i    = 64'h8000_0014;
    pc_i          = 64'h8000_0040;
    inst_valid_i  = 1'b1;
    mret_i        = 1'b1;
    expect_out("mret.T0", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    tick; quiet;
    expect_out("mret.T1", 1'b1, 12'h300, 64'h1888, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("mret.T2", 1'b0, 12'h000, 64'd0, 1'b1, 64'h8000_0014, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("mret.T3", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Pipeline CSR write for 2 cycles during SAVE_CAUSE: redirect slips to T+6
    tick;
    quiet;
    csr_mstatus_i = 64'h1888;
    csr_mtvec_i   = 64'h8000_2000;
    pc_i          = 64'h8000_0050;
    inst_valid_i  = 1'b1;
    ecall_i       = 1'b1;
    expect_out("cfl.T0", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    tick; quiet;
    expect_out("cfl.T1", 1'b1, 12'h341, 64'h8000_0050, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick; cpu_csr_wen_i = 1'b1;
    expect_out("cfl.T2", 1'b1, 12'h342, 64'd11, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick; cpu_csr_wen_i = 1'b1;
    expect_out("cfl.T3", 1'b1, 12'h342, 64'd11, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick; cpu_csr_wen_i = 1'b0;
    expect_out("cfl.T4", 1'b1, 12'h342, 64'd11, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("cfl.T5", 1'b1, 12'h300, 64'h1880, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("cfl.T6", 1'b0, 12'h000, 64'd0, 1'b1, 64'h8000_2000, 1'b1, 1'b1, 1'b0);
    tick;
    expect_out("cfl.T7", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Reset at T+2 of a trap: abort, no mstatus write, no redirect
    tick;
    quiet;
    csr_mtvec_i  = 64'h8000_1000;
    pc_i         = 64'h8000_0060;
    inst_valid_i = 1'b1;
    ecall_i      = 1'b1;
    expect_out("rst.T0", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    tick; quiet;
    expect_out("rst.T1", 1'b1, 12'h341, 64'h8000_0060, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    tick; rst_n = 1'b0;
    tick; rst_n = 1'b1;
    expect_out("rst.T3", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    tick;
    expect_out("rst.T4", 1'b0, 12'h000, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Ecall after the abort is handled normally
    ecall_seq("post", 64'h8000_0070, 64'h8000_3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer for the CSR file. It detects a committing `ecall`, an `mret` or a pending machine timer interrupt, and writes mepc, mcause and mstatus one per cycle through the CSR file's clint write port. It then redirects the fetch PC. It sits between the commit stage and the CSR file, and owns the clint port exclusively.

## Interface
Parameters:
- `MCAUSE_ECALL`, default 64'd11: mcause value for environment call from M-mode.
- `MCAUSE_MTI`, default 64'h8000_0000_0000_0007: mcause value for machine timer interrupt.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `inst_valid_i` in 1: a valid instruction is at commit this cycle.
- `pc_i` in 64: PC of the committing instruction.
- `ecall_i` in 1: committing instruction is `ecall`.
- `mret_i` in 1: committing instruction is `mret`.
- `cpu_csr_wen_i` in 1: pipeline CSR write this cycle. That write has priority in the CSR file.
- `csr_mtvec_i` in 64: mtvec from the CSR file.
- `csr_mepc_i` in 64: mepc from the CSR file.
- `csr_mstatus_i` in 64: mstatus from the CSR file.
- `global_int_en_i` in 1: mstatus.MIE.
- `mtime_int_en_i` in 1: mie.MTIE.
- `mtime_int_pend_i` in 1: mip.MTIP.
- `csr_wen_o` out 1: clint CSR write enable.
- `csr_waddr_o` out 12: clint CSR write address. Uses 0x300 mstatus, 0x341 mepc, 0x342 mcause.
- `csr_wdata_o` out 64: clint CSR write data.
- `stall_o` out 1: freeze fetch, decode and commit.
- `flush_o` out 1: kill all instructions younger than commit.
- `redirect_valid_o` out 1: one-cycle PC redirect strobe.
- `redirect_pc_o` out 64: new fetch PC.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SET_STATUS, TRAP_JUMP, MRET_STATUS, MRET_JUMP.
- Event detection is evaluated only in IDLE and qualified by `inst_valid_i`:
  - Interrupt condition: `global_int_en_i & mtime_int_en_i & mtime_int_pend_i`.
  - Priority: interrupt > ecall > mret.
  - On an interrupt, the committing instruction is not retired.
- Accept cycle:
  - Latch `epc_q <= pc_i`.
  - Latch `cause_q <=` MCAUSE_MTI or MCAUSE_ECALL.
  - Latch `is_int_q`.
  - Assert `flush_o`.
  - Next state is SAVE_EPC for a trap, MRET_STATUS for an mret.
- SAVE_EPC: write 0x341 with `epc_q`.
- SAVE_CAUSE: write 0x342 with `cause_q`.
- SET_STATUS: write 0x300 with `csr_mstatus_i` modified as follows:
  - bit7 (MPIE) = bit3.
  - bit3 (MIE) = 0.
  - bits12:11 (MPP) = 2'b11.
  - All other bits unchanged.
- TRAP_JUMP:
  - Assert `redirect_valid_o`.
  - `redirect_pc_o = {mtvec[63:2],2'b00}`.
  - If `mtvec[1:0]==2'b01` and `is_int_q`, `redirect_pc_o = {mtvec[63:2],2'b00} + 4*cause_q[5:0]`, i.e. base+28 for MTI.
  - Next state is IDLE.
- MRET_STATUS: write 0x300 with `csr_mstatus_i` modified as follows:
  - MIE = old MPIE.
  - MPIE = 1.
  - MPP = 2'b11.
- MRET_JUMP: `redirect_valid_o=1`, `redirect_pc_o = csr_mepc_i`, next state is IDLE.
- Write-port conflict: in any write state with `cpu_csr_wen_i=1`:
  - Keep `csr_wen_o`, address and data asserted.
  - Do not advance; retry next cycle.
- `stall_o = busy_o | accept`. Events arriving while busy are ignored; the stalled pipeline re-presents them.
- MTIP is sticky in the CSR file. MIE cleared by SET_STATUS prevents re-entry until `mret`.

## Timing
- Reset values:
  - State IDLE.
  - `epc_q`, `cause_q`, `is_int_q` = 0.
  - All outputs 0.
- Reset mid-sequence: synchronous abort to IDLE the next edge. No further CSR writes and no redirect.
- Trap latency with no conflicts, accept at cycle T:
  - mepc write at T+1.
  - mcause write at T+2.
  - mstatus write at T+3.
  - Redirect at T+4.
  - Back in IDLE at T+5.
- Mret latency with no conflicts, accept at cycle T:
  - mstatus write at T+1.
  - Redirect at T+2.
- Each `cpu_csr_wen_i` cycle during a write state adds exactly one cycle.
- `csr_*`, `redirect_*` and `busy_o` are decoded from registered state and latches. `flush_o` and the accept term of `stall_o` are combinational from the inputs in IDLE.
- `csr_wen_o` is high only in the write states, exactly one cycle per write absent conflict.

## Test plan
- Ecall: `pc_i`=0x8000_0010, mstatus=0x1888, mtvec=0x8000_1000 -> writes 0x341←0x8000_0010 (T+1), 0x342←11 (T+2), 0x300←0x1880 (T+3); redirect 0x8000_1000 at T+4.
- Timer with vectored mtvec=0x8000_1001, all enables set -> mcause 0x8000_0000_0000_0007; redirect 0x8000_101C.
- Simultaneous interrupt and ecall at the same commit -> the interrupt is taken, mepc = ecall PC, one sequence only.
- Mret with mstatus=0x1880, mepc=0x8000_0014 -> 0x300←0x1888 at T+1; redirect 0x8000_0014 at T+2.
- `cpu_csr_wen_i` high during SAVE_CAUSE for 2 cycles -> the mcause write is held 3 cycles total; redirect slips to T+6.
- `rst_n` low at T+2 of a trap -> no mstatus write, no redirect, all outputs 0 the next cycle; an ecall afterwards is handled normally.
